// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a byte stream into 32-bit words, writes them
// to consecutive word addresses, then redirects the CPU to the load address.
module imem_loader #(
  parameter int BIG_END = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   num_words,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          INT,
  output logic [AW-1:0] entryPoint,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_LAUNCH  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [15:0]   num_q, num_d;
  logic [15:0]   idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   word_q, word_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          int_q, int_d;
  logic [AW-1:0] entry_q, entry_d;
  logic          done_q, done_d;

  logic          xfer_s;
  logic [31:0]   shifted_s;

  // abort wins over a same-cycle byte, so the handshake must be masked combinationally
  assign xfer_s = in_ready_q & in_valid & ~abort;

  // Byte insertion according to the configured byte order
  always_comb begin
    if (BIG_END != 0) begin
      shifted_s = {word_q[23:0], in_data};
    end else begin
      shifted_s = {in_data, word_q[31:8]};
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    idx_d       = idx_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    entry_d     = entry_q;
    mem_we_d    = 1'b0;
    int_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != 16'd0) begin
            base_d  = base_addr & ~(AW'(32'd3));
            num_d   = num_words;
            idx_d   = 16'd0;
            bcnt_d  = 2'd0;
            word_d  = 32'd0;
            state_d = S_COLLECT;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer_s) begin
          word_d = shifted_s;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = base_q + AW'({idx_q, 2'b00});
            mem_wdata_d = shifted_s;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 16'd1;
          if ((idx_q + 16'd1) == num_q) begin
            state_d = S_LAUNCH;
            int_d   = 1'b1;
            done_d  = 1'b1;
            entry_d = base_q;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered
    in_ready_d = (state_d == S_COLLECT);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= 16'd0;
      idx_q       <= 16'd0;
      bcnt_q      <= 2'd0;
      word_q      <= 32'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      int_q       <= 1'b0;
      entry_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      int_q       <= int_d;
      entry_q     <= entry_d;
      done_q      <= done_d;
    end
  end

  assign in_ready   = in_ready_q & ~abort;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign INT        = int_q;
  assign entryPoint = entry_q;
  assign done       = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: big- and little-endian instances share one stimulus stream
// and are checked against a word-list model built from the byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] num_words = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        be_in_ready, be_we, be_busy, be_int, be_done;
  logic [31:0] be_addr, be_wdata, be_entry;
  logic        le_in_ready, le_we, le_busy, le_int, le_done;
  logic [31:0] le_addr, le_wdata, le_entry;

  imem_loader #(.BIG_END(1), .AW(32)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data), .in_ready(be_in_ready),
    .mem_we(be_we), .mem_addr(be_addr), .mem_wdata(be_wdata), .busy(be_busy),
    .INT(be_int), .entryPoint(be_entry), .done(be_done)
  );

  imem_loader #(.BIG_END(0), .AW(32)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data), .in_ready(le_in_ready),
    .mem_we(le_we), .mem_addr(le_addr), .mem_wdata(le_wdata), .busy(le_busy),
    .INT(le_int), .entryPoint(le_entry), .done(le_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int start_cyc = 0;
  int int_cnt = 0, le_int_cnt = 0, done_cnt = 0, busy_cnt = 0, int_cyc = 0;
  logic [31:0] int_entry = 32'd0, le_int_entry = 32'd0;
  logic [63:0] obs_be[$];
  logic [63:0] obs_le[$];
  logic [63:0] exp_be[$];
  logic [63:0] exp_le[$];
  logic [7:0]  stim[$];

  // Free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Observe write strobes and pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (be_we) obs_be.push_back({be_addr, be_wdata});
      if (le_we) obs_le.push_back({le_addr, le_wdata});
      if (be_int) begin
        int_cnt   <= int_cnt + 1;
        int_cyc   <= cyc;
        int_entry <= be_entry;
      end
      if (le_int) begin
        le_int_cnt   <= le_int_cnt + 1;
        le_int_entry <= le_entry;
      end
      if (be_done) done_cnt <= done_cnt + 1;
      if (be_busy) busy_cnt <= busy_cnt + 1;
    end
  end

  // Reference: word w is bytes 4w..4w+3 placed at aligned base + 4w (mod 2^32)
  function automatic void build_expected(input logic [31:0] base, input int n);
    logic [31:0] a;
    exp_be.delete();
    exp_le.delete();
    for (int w = 0; w < n; w++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * w);
      exp_be.push_back({a, stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]});
      exp_le.push_back({a, stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]});
    end
  endfunction

  function automatic void random_stim(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endfunction

  task automatic issue_start(input logic [31:0] base, input int n);
    base_addr = base;
    num_words = n[15:0];
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // vmode 0: valid held high, 1: toggled every other cycle, 2: random
  task automatic drive_stream(input int vmode, input int max_bytes, input int restart_at);
    int  ptr = 0;
    int  budget = 0;
    bit  hs;
    bit  restarted = 1'b0;
    while (ptr < max_bytes && budget < 600) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (budget % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = stim[ptr];
      if (ptr == restart_at && !restarted) begin
        restarted = 1'b1;
        start     = 1'b1;
        base_addr = 32'h0000_0400;
        num_words = 16'd1;
      end
      @(negedge clk);
      hs = in_valid && be_in_ready;
      @(posedge clk);
      #1 start = 1'b0;
      if (hs) ptr++;
      budget++;
    end
    in_valid = 1'b0;
    vectors++;
    if (ptr != max_bytes) begin
      miscompares++;
      $display("FAIL stream_timeout bytes_taken=%0d required=%0d", ptr, max_bytes);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({be_in_ready, be_we, be_addr, be_wdata, be_busy, be_int, be_entry, be_done} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_be got=%b%b %h %h %b%b %h %b required all zero", be_in_ready, be_we,
               be_addr, be_wdata, be_busy, be_int, be_entry, be_done);
    end
    vectors++;
    if ({le_in_ready, le_we, le_addr, le_wdata, le_busy, le_int, le_entry, le_done} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_le outputs not zero");
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({be_in_ready, be_we, be_busy, be_int, be_done} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_release got=%b required=00000", {be_in_ready, be_we, be_busy, be_int, be_done});
    end
  endtask

  task automatic test_spec_stream();
    int mb = obs_be.size();
    int ml = obs_le.size();
    int ic = int_cnt;
    int dc = done_cnt;
    logic [63:0] got;
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
    build_expected(32'h80, 2);
    issue_start(32'h80, 2);
    drive_stream(0, 8, -1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_be.size() - mb != 2) begin
      miscompares++;
      $display("FAIL spec_write_count got=%0d required=2", obs_be.size() - mb);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      got = (mb + i < obs_be.size()) ? obs_be[mb+i] : 64'hx;
      if (got !== exp_be[i]) begin
        miscompares++;
        $display("FAIL spec_be_write%0d got=%h required=%h", i, got, exp_be[i]);
      end
      vectors++;
      got = (ml + i < obs_le.size()) ? obs_le[ml+i] : 64'hx;
      if (got !== exp_le[i]) begin
        miscompares++;
        $display("FAIL spec_le_write%0d got=%h required=%h", i, got, exp_le[i]);
      end
    end
    vectors++;
    if (int_cnt - ic != 1 || int_entry !== 32'h80) begin
      miscompares++;
      $display("FAIL spec_int pulses=%0d entry=%h required 1 at 00000080", int_cnt - ic, int_entry);
    end
    vectors++;
    if (int_cyc - start_cyc + 1 != 12) begin
      miscompares++;
      $display("FAIL spec_latency got_cycle=%0d required=12", int_cyc - start_cyc + 1);
    end
    vectors++;
    if (done_cnt - dc != 1) begin
      miscompares++;
      $display("FAIL spec_done pulses=%0d required=1", done_cnt - dc);
    end
    vectors++;
    if (be_addr !== 32'h84 || be_wdata !== 32'h8C09_0000 || be_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL spec_hold addr=%h data=%h busy=%b required 00000084 8c090000 0", be_addr, be_wdata, be_busy);
    end
  endtask

  task automatic test_unaligned_toggle();
    int mb = obs_be.size();
    int ic = int_cnt;
    logic [63:0] got;
    random_stim(4);
    build_expected(32'h83, 1);
    issue_start(32'h83, 1);
    drive_stream(1, 4, -1);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    got = (obs_be.size() == mb + 1) ? obs_be[mb] : 64'hx;
    if (got !== exp_be[0]) begin
      miscompares++;
      $display("FAIL unaligned_write got=%h required=%h count=%0d", got, exp_be[0], obs_be.size() - mb);
    end
    vectors++;
    if (int_cnt - ic != 1 || int_entry !== 32'h80) begin
      miscompares++;
      $display("FAIL unaligned_int pulses=%0d entry=%h required 1 at 00000080", int_cnt - ic, int_entry);
    end
  endtask

  task automatic test_zero_words();
    int mb = obs_be.size();
    int ic = int_cnt;
    int dc = done_cnt;
    int bc = busy_cnt;
    issue_start(32'h40, 0);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt - dc != 1 || int_cnt - ic != 0 || obs_be.size() != mb || busy_cnt != bc) begin
      miscompares++;
      $display("FAIL zero_words done=%0d int=%0d writes=%0d busy_cycles=%0d required 1 0 0 0",
               done_cnt - dc, int_cnt - ic, obs_be.size() - mb, busy_cnt - bc);
    end
  endtask

  task automatic test_abort();
    int mb = obs_be.size();
    int ic = int_cnt;
    int dc = done_cnt;
    logic [63:0] got;
    random_stim(12);
    issue_start(32'h200, 3);
    drive_stream(0, 2, -1);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = stim[2];
    #1;
    vectors++;
    if (be_in_ready !== 1'b0 || le_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready got=%b%b required=00", be_in_ready, le_in_ready);
    end
    @(posedge clk);
    #1 abort = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (be_busy !== 1'b0 || obs_be.size() != mb || int_cnt != ic || done_cnt != dc) begin
      miscompares++;
      $display("FAIL abort_quiet busy=%b writes=%0d int=%0d done=%0d required 0 0 0 0",
               be_busy, obs_be.size() - mb, int_cnt - ic, done_cnt - dc);
    end
    random_stim(8);
    build_expected(32'h100, 2);
    issue_start(32'h100, 2);
    drive_stream(0, 8, -1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      got = (mb + i < obs_be.size()) ? obs_be[mb+i] : 64'hx;
      if (got !== exp_be[i]) begin
        miscompares++;
        $display("FAIL abort_reload_write%0d got=%h required=%h", i, got, exp_be[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int nwe = 0;
    int ic;
    int mb;
    logic [63:0] got;
    issue_start(32'h300, 4);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && nwe < 2; k++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (be_we) nwe++;
    end
    ic = int_cnt;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (nwe != 2) begin
      miscompares++;
      $display("FAIL rst_mid_wait writes_seen=%0d required=2", nwe);
    end
    vectors++;
    if ({be_in_ready, be_we, be_addr, be_wdata, be_busy, be_int, be_entry, be_done,
         le_in_ready, le_we, le_addr, le_wdata, le_busy, le_int, le_entry, le_done} !== 200'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async we=%b addr=%h data=%h busy=%b required all zero",
               be_we, be_addr, be_wdata, be_busy);
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({be_in_ready, be_we, be_busy, be_int, be_done} !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_mid_release got=%b required=00000", {be_in_ready, be_we, be_busy, be_int, be_done});
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (int_cnt != ic) begin
      miscompares++;
      $display("FAIL rst_mid_no_int pulses=%0d required=0", int_cnt - ic);
    end
    mb = obs_be.size();
    ic = int_cnt;
    random_stim(8);
    build_expected(32'h500, 2);
    issue_start(32'h500, 2);
    drive_stream(2, 8, 3);
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_be.size() - mb != 2) begin
      miscompares++;
      $display("FAIL busy_start_count got=%0d required=2", obs_be.size() - mb);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      got = (mb + i < obs_be.size()) ? obs_be[mb+i] : 64'hx;
      if (got !== exp_be[i]) begin
        miscompares++;
        $display("FAIL busy_start_write%0d got=%h required=%h", i, got, exp_be[i]);
      end
    end
    vectors++;
    if (int_cnt - ic != 1 || int_entry !== 32'h500) begin
      miscompares++;
      $display("FAIL busy_start_int pulses=%0d entry=%h required 1 at 00000500", int_cnt - ic, int_entry);
    end
  endtask

  task automatic test_random_loads();
    logic [31:0] base;
    logic [63:0] got;
    int n, mb, ml, ic, lic;
    for (int t = 0; t < 6; t++) begin
      base = (t == 0) ? 32'hFFFF_FFF9 : $urandom;
      n    = (t == 0) ? 4 : $urandom_range(1, 4);
      random_stim(4 * n);
      build_expected(base, n);
      mb  = obs_be.size();
      ml  = obs_le.size();
      ic  = int_cnt;
      lic = le_int_cnt;
      issue_start(base, n);
      drive_stream(2, 4 * n, -1);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
        vectors++;
        got = (mb + i < obs_be.size()) ? obs_be[mb+i] : 64'hx;
        if (got !== exp_be[i]) begin
          miscompares++;
          $display("FAIL random%0d_be_write%0d got=%h required=%h", t, i, got, exp_be[i]);
        end
        vectors++;
        got = (ml + i < obs_le.size()) ? obs_le[ml+i] : 64'hx;
        if (got !== exp_le[i]) begin
          miscompares++;
          $display("FAIL random%0d_le_write%0d got=%h required=%h", t, i, got, exp_le[i]);
        end
      end
      vectors++;
      if (obs_be.size() - mb != n || int_cnt - ic != 1 || le_int_cnt - lic != 1 ||
          int_entry !== (base & 32'hFFFF_FFFC) || le_int_entry !== (base & 32'hFFFF_FFFC)) begin
        miscompares++;
        $display("FAIL random%0d_launch writes=%0d int=%0d entry=%h required %0d 1 %h", t,
                 obs_be.size() - mb, int_cnt - ic, int_entry, n, base & 32'hFFFF_FFFC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_stream();
    test_unaligned_toggle();
    test_zero_words();
    test_abort();
    test_reset_mid_write();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
